imem_fetch_unit: RTL and testbench

- Parametrised successor to the single-cycle CPU instruction memory.
- Adds synchronous read with configurable latency, a request/response fetch handshake, a program-load write port and out-of-range detection.
- Sits between the PC/fetch stage and the decoder; the program loader drives the load port before or between runs.

---
 rtl/imem_fetch_unit.sv | 137 +++++++++++++
 tb/tb_imem_fetch_unit.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch_unit.sv
// imem_fetch_unit: instruction memory with a request/response fetch handshake,
// configurable synchronous read latency, a program-load write port and
// out-of-range detection.
// Optional next-line prefetch buffer: define IMEM_PREFETCH_EN.
module imem_fetch_unit #(
   parameter int            DW        = 16,
   parameter int            AW        = 12,
   parameter int            DEPTH     = 256,
   parameter int            READ_LAT  = 1,
   parameter logic [DW-1:0] OOR_INS   = 16'h9000,
   parameter                INIT_FILE = ""
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          fetch_req,
   input  logic [AW-1:0] fetch_addr,
   output logic          fetch_ready,
   output logic          fetch_valid,
   output logic [DW-1:0] fetch_ins,
   output logic          fetch_err,
   input  logic          fetch_ack,
   input  logic          load_en,
   input  logic [AW-1:0] load_addr,
   input  logic [DW-1:0] load_data,
   output logic          load_busy
);

   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;
   localparam logic [1:0] CNT0   = 2'(READ_LAT - 1);

   logic [DW-1:0] mem [0:DEPTH-1];
   logic [1:0]    state;
   logic [1:0]    cnt;
   logic [AW-1:0] addr_q;
   logic [AW-1:0] rd_addr;
   logic          accept, load_ok, rd_go, rd_oor;
   logic          pf_hit;
   logic [DW-1:0] pf_data;

   function automatic logic in_rng(input logic [AW-1:0] a);
      return 32'(a) < DEPTH;
   endfunction

   initial begin
      for (int i = 0; i < DEPTH; i++) mem[i] = '0;
   end

   assign load_busy   = (state != S_IDLE);
   assign fetch_ready = (state == S_IDLE) && !load_en;
   assign fetch_valid = (state == S_RESP);
   assign accept      = fetch_req && fetch_ready;
   assign load_ok     = rst_n && load_en && (state == S_IDLE) && in_rng(load_addr);

   // Memory read happens on the edge that enters RESP on a miss path.
   assign rd_go   = (accept && !pf_hit && (READ_LAT == 1)) ||
                    ((state == S_WAIT) && (cnt == 2'd1));
   assign rd_addr = (state == S_IDLE) ? fetch_addr : addr_q;
   assign rd_oor  = !in_rng(rd_addr);

   // Program-load write port; only honoured while idle, out-of-range dropped.
   always_ff @(posedge clk) begin
      if (load_ok) mem[load_addr[IW-1:0]] <= load_data;
   end

   // Fetch control FSM.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= S_IDLE;
         cnt    <= '0;
         addr_q <= '0;
      end else begin
         case (state)
            S_IDLE: if (accept) begin
               addr_q <= fetch_addr;
               if (pf_hit || (READ_LAT == 1)) state <= S_RESP;
               else begin
                  state <= S_WAIT;
                  cnt   <= CNT0;
               end
            end
            S_WAIT: if (cnt == 2'd1) state <= S_RESP;
                    else             cnt   <= cnt - 2'd1;
            S_RESP: if (fetch_ack) state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   // Registered response word; held stable through RESP.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fetch_ins <= '0;
         fetch_err <= 1'b0;
      end else if (rd_go) begin
         fetch_ins <= rd_oor ? OOR_INS : mem[rd_addr[IW-1:0]];
         fetch_err <= rd_oor;
      end else if (accept && pf_hit) begin
         fetch_ins <= pf_data;
         fetch_err <= 1'b0;
      end
   end

`ifdef IMEM_PREFETCH_EN
   logic          pf_valid, pf_pend;
   logic [AW-1:0] pf_addr, pf_nxt;

   assign pf_nxt = addr_q + AW'(1);
   // The prefetch cycle itself never hits: the buffer still holds stale state.
   assign pf_hit = pf_valid && !pf_pend && (fetch_addr == pf_addr);

   // Next-line buffer: filled the cycle after an ack, cleared by loads and misses.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pf_valid <= 1'b0;
         pf_pend  <= 1'b0;
         pf_addr  <= '0;
         pf_data  <= '0;
      end else begin
         pf_pend <= (state == S_RESP) && fetch_ack;
         if ((load_en && (state == S_IDLE)) || (accept && !pf_hit)) begin
            pf_valid <= 1'b0;
         end else if (pf_pend) begin
            pf_valid <= (32'(addr_q) + 1) < DEPTH;
            pf_addr  <= pf_nxt;
            pf_data  <= mem[pf_nxt[IW-1:0]];
         end
      end
   end
`else
   assign pf_hit  = 1'b0;
   assign pf_data = '0;
`endif

endmodule

// File: tb/tb_imem_fetch_unit.sv
// Bench for imem_fetch_unit: two instances (READ_LAT=1 and 3) checked against
// a word-array memory model with a latency rule derived from the fetch protocol.
module tb_imem_fetch_unit;

   localparam int DEPTH = 256;
`ifdef IMEM_PREFETCH_EN
   localparam bit PF = 1'b1;
`else
   localparam bit PF = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req [2];
   logic [11:0] faddr [2];
   logic        ack [2];
   logic        len [2];
   logic [11:0] laddr [2];
   logic [15:0] ldata [2];
   logic        ready [2];
   logic        valid [2];
   logic [15:0] ins [2];
   logic        err [2];
   logic        busy [2];

   int          checks = 0;
   int          failures = 0;
   int          rl [2] = '{1, 3};
   logic [15:0] mdl [2][DEPTH];
   bit          pfv [2];
   int          pfa [2];

   always #5 clk = ~clk;

   imem_fetch_unit #(.READ_LAT(1)) u0 (
      .clk(clk), .rst_n(rst_n), .fetch_req(req[0]), .fetch_addr(faddr[0]),
      .fetch_ready(ready[0]), .fetch_valid(valid[0]), .fetch_ins(ins[0]),
      .fetch_err(err[0]), .fetch_ack(ack[0]), .load_en(len[0]),
      .load_addr(laddr[0]), .load_data(ldata[0]), .load_busy(busy[0]));

   imem_fetch_unit #(.READ_LAT(3)) u1 (
      .clk(clk), .rst_n(rst_n), .fetch_req(req[1]), .fetch_addr(faddr[1]),
      .fetch_ready(ready[1]), .fetch_valid(valid[1]), .fetch_ins(ins[1]),
      .fetch_err(err[1]), .fetch_ack(ack[1]), .load_en(len[1]),
      .load_addr(laddr[1]), .load_data(ldata[1]), .load_busy(busy[1]));

   task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s dut%0d got=%0h exp=%0h", tag, d, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_load(input int d, input int a, input logic [15:0] v);
      len[d] = 1'b1; laddr[d] = 12'(a); ldata[d] = v;
      step();
      len[d] = 1'b0;
      if (a < DEPTH) mdl[d][a] = v;
      pfv[d] = 1'b0;
   endtask

   // Full fetch transaction; optional dropped load while the fetch is in flight.
   task automatic do_fetch(input int d, input int a, input int hold, input bit busy_load);
      int          lat, exp_lat;
      logic [15:0] exp_ins;
      logic        exp_err;
      exp_lat = (PF && pfv[d] && pfa[d] == a) ? 1 : rl[d];
      exp_err = (a >= DEPTH);
      exp_ins = exp_err ? 16'h9000 : mdl[d][a];
      req[d] = 1'b1; faddr[d] = 12'(a);
      #1;
      chk("ready_idle", d, 32'(ready[d]), 1);
      step();
      req[d] = 1'b0;
      lat = 1;
      if (busy_load && !valid[d]) begin
         chk("busy_wait", d, 32'(busy[d]), 1);
         chk("ready_wait", d, 32'(ready[d]), 0);
         len[d] = 1'b1; laddr[d] = 12'(a); ldata[d] = ~exp_ins;
         step();
         len[d] = 1'b0;
         lat++;
      end
      while (!valid[d] && lat < 20) begin
         step();
         lat++;
      end
      chk("latency", d, 32'(lat), 32'(exp_lat));
      chk("ins", d, 32'(ins[d]), 32'(exp_ins));
      chk("err", d, 32'(err[d]), 32'(exp_err));
      repeat (hold) begin
         step();
         chk("hold_valid", d, 32'(valid[d]), 1);
         chk("hold_ins", d, 32'(ins[d]), 32'(exp_ins));
         chk("hold_ready", d, 32'(ready[d]), 0);
      end
      ack[d] = 1'b1;
      step();
      ack[d] = 1'b0;
      chk("valid_drop", d, 32'(valid[d]), 0);
      chk("ready_after", d, 32'(ready[d]), 1);
      step();
      pfv[d] = (a + 1) < DEPTH;
      pfa[d] = a + 1;
   endtask

   initial begin
      int d, a, op;
      rst_n = 1'b0;
      for (int i = 0; i < 2; i++) begin
         req[i] = 0; faddr[i] = 0; ack[i] = 0; len[i] = 0; laddr[i] = 0; ldata[i] = 0;
         pfv[i] = 0; pfa[i] = 0;
         for (int j = 0; j < DEPTH; j++) mdl[i][j] = 16'h0;
      end
      step(); step();
      rst_n = 1'b1;
      for (int i = 0; i < 2; i++) begin
         chk("rst_valid", i, 32'(valid[i]), 0);
         chk("rst_ins", i, 32'(ins[i]), 0);
         chk("rst_err", i, 32'(err[i]), 0);
         chk("rst_busy", i, 32'(busy[i]), 0);
         chk("rst_ready", i, 32'(ready[i]), 1);
      end

      // Basic load/fetch at latency 1, then latency 3 with a held ack.
      do_load(0, 2, 16'h2003);
      do_fetch(0, 2, 0, 0);
      do_fetch(1, 0, 5, 0);

      // Out-of-range fetches on both instances.
      do_fetch(0, 12'h100, 1, 0);
      do_fetch(1, 12'hFFF, 0, 0);

      // Load and fetch together: load wins, then read-after-write.
      len[0] = 1; laddr[0] = 12'd9; ldata[0] = 16'h1234;
      req[0] = 1; faddr[0] = 12'd9;
      #1;
      chk("ready_load", 0, 32'(ready[0]), 0);
      chk("busy_load", 0, 32'(busy[0]), 0);
      step();
      len[0] = 0; req[0] = 0;
      mdl[0][9] = 16'h1234; pfv[0] = 0;
      chk("no_accept", 0, 32'(valid[0]), 0);
      chk("no_accept_busy", 0, 32'(busy[0]), 0);
      do_fetch(0, 9, 0, 0);

      // Out-of-range load is dropped.
      do_load(1, 300, 16'hBEEF);
      do_fetch(1, 300, 0, 0);

      // Load during WAIT is dropped; confirm by refetch.
      do_load(1, 3, 16'h0333);
      do_fetch(1, 3, 2, 1);
      do_fetch(1, 3, 0, 0);

      // Reset during WAIT aborts the fetch.
      req[1] = 1; faddr[1] = 12'd4;
      step();
      req[1] = 0;
      step();
      rst_n = 0;
      step();
      rst_n = 1;
      pfv[0] = 0; pfv[1] = 0;
      begin
         int seen = 0;
         repeat (8) begin
            if (valid[1]) seen++;
            step();
         end
         chk("abort_no_valid", 1, 32'(seen), 0);
      end
      chk("abort_ins", 1, 32'(ins[1]), 0);
      chk("abort_err", 1, 32'(err[1]), 0);
      chk("abort_busy", 1, 32'(busy[1]), 0);
      chk("abort_ready", 1, 32'(ready[1]), 1);

      // Next-line sequence, then the same with an intervening load.
      do_load(1, 6, 16'h6006);
      do_fetch(1, 5, 0, 0);
      do_fetch(1, 6, 0, 0);
      do_fetch(1, 5, 0, 0);
      do_load(1, 77, 16'h7777);
      do_fetch(1, 6, 1, 0);

      // Randomized mix of loads and fetches.
      for (int it = 0; it < 80; it++) begin
         d  = int'($urandom_range(0, 1));
         op = int'($urandom_range(0, 9));
         if (op < 3) begin
            a = int'($urandom_range(0, 300));
            do_load(d, a, 16'($urandom));
         end else begin
            if (op < 6) a = pfa[d];
            else if (op < 9) a = int'($urandom_range(0, 300));
            else a = int'($urandom_range(0, 4095));
            do_fetch(d, a, int'($urandom_range(0, 3)), 0);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
